// File: rtl/mips_cpu_load_store_unit.sv
// Data-memory initiator: one load/store at a time, lane steering, wait/timeout handling.
// Optional `LSU_ALIGN_CHECK_EN: misaligned half/word accesses respond with an error, no strobe.
module mips_cpu_load_store_unit #(
    parameter int WAIT_LIMIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata
);

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;
    logic [31:0] wait_cnt;
    logic        is_byte, is_half, misalign_err, timeout, is_load_q;
    logic [1:0]  lane;
    logic [3:0]  be;
    logic [31:0] wd, load_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign is_byte   = req_op inside {3'd0, 3'd1, 3'd5};
    assign is_half   = req_op inside {3'd2, 3'd3, 3'd6};
    assign is_load_q = op_q <= OP_LW;

    always_comb begin
        lane = 2'b00;
        be   = 4'b1111;
        wd   = req_wdata;
        unique case (1'b1)
            is_byte: begin
                lane = req_addr[1:0];
                be   = 4'b0001 << req_addr[1:0];
                wd   = {4{req_wdata[7:0]}};
            end
            is_half: begin
                lane = {req_addr[1], 1'b0};
                be   = req_addr[1] ? 4'b1100 : 4'b0011;
                wd   = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef LSU_ALIGN_CHECK_EN
    assign misalign_err = (is_half && req_addr[0]) ||
                          (!is_byte && !is_half && req_addr[1:0] != 2'b00);
`else
    assign misalign_err = 1'b0;
`endif

    assign timeout = (WAIT_LIMIT > 0) && mem_waitrequest &&
                     (wait_cnt == 32'(WAIT_LIMIT - 1));

    always_comb begin
        byte_sel  = mem_readdata[{lane_q, 3'b000} +: 8];
        half_sel  = lane_q[1] ? mem_readdata[31:16] : mem_readdata[15:0];
        load_data = '0;
        unique case (op_q)
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'd0, byte_sel};
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'd0, half_sel};
            OP_LW:   load_data = mem_readdata;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_nxt = misalign_err ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_read  = is_load_q;
                mem_write = !is_load_q;
                if (timeout || !mem_waitrequest)
                    state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            op_q           <= '0;
            lane_q         <= '0;
            wait_cnt       <= '0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_writedata  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                op_q           <= req_op;
                lane_q         <= lane;
                wait_cnt       <= '0;
                mem_address    <= {req_addr[31:2], 2'b00};
                mem_byteenable <= be;
                mem_writedata  <= wd;
                if (misalign_err) begin
                    resp_err   <= 1'b1;
                    resp_rdata <= '0;
                end
            end
            if (state == ACCESS) begin
                if (timeout) begin
                    resp_err   <= 1'b1;
                    resp_rdata <= '0;
                end else if (mem_waitrequest) begin
                    wait_cnt <= wait_cnt + 32'd1;
                end else begin
                    resp_err   <= 1'b0;
                    resp_rdata <= load_data;
                end
            end
        end
    end

endmodule
